// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
// Operands are taken over an in_valid/in_ready handshake. DIGIT bits per
// clock pass through a ripple chain of full-adder cells, and a flip-flop
// carries between digits. sum/cout/ovf/zero are returned over an
// out_valid/out_ready handshake.
// Subtraction uses a - b - cin = a + ~b + !cin, so cout is the raw carry
// (1 = no borrow).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands; result registers hold last op
// RUN   | one digit per cycle; counter selects the last step
// DONE  | out_valid=1, all outputs frozen until out_ready

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // reject geometries the digit chain cannot cover exactly
  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_c_top;
  logic             chain_c;
  logic [WIDTH-1:0] res_next;

  // ripple through DIGIT full-adder cells on the low bits of the operands;
  // dig_c_top keeps the carry into the top cell (bit WIDTH-1 on the last step)
  always_comb begin
    chain_c   = carry;
    dig_sum   = '0;
    dig_c_top = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      dig_c_top  = chain_c;
      dig_sum[i] = a_r[i] ^ b_r[i] ^ chain_c;
      chain_c    = (a_r[i] & b_r[i]) | (chain_c & (a_r[i] ^ b_r[i]));
    end
    dig_cout = chain_c;
  end

  // new digit enters the top of the result register, older digits move down
  if (DIGIT == WIDTH) begin : g_parallel
    assign res_next = dig_sum;
  end else begin : g_serial
    assign res_next = {dig_sum, res_r[WIDTH-1:DIGIT]};
  end

  // handshake FSM with the operand, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry    <= cin ^ sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          res_r <= res_next;
          carry <= dig_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout      <= dig_cout;
            ovf       <= dig_c_top ^ dig_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum  = res_r;
  assign zero = (res_r == '0);

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised digit-serial adder/subtractor. It accepts two WIDTH-bit operands over a valid/ready handshake and processes DIGIT bits per clock through a chain of full-adder cells, holding the carry in a flip-flop between steps. It returns sum, carry-out, signed-overflow and zero flags over a second valid/ready handshake. It is the sequential, multi-bit, mode-selectable successor to the single-bit full-adder cell, intended for area-constrained arithmetic datapaths.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 1: bits processed per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise).
- STEPS (localparam) = WIDTH/DIGIT: number of compute cycles.

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: latch A=a, B=sub ? ~b : b, carry=cin^sub, clear step counter; → RUN. Inputs are ignored in every other state.
- RUN: each cycle adds the low DIGIT bits of A and B plus carry through DIGIT chained full-adder cells. Shifts A and B right by DIGIT and shifts the DIGIT result bits into the top of the result register. Updates carry and increments the counter.
- On the step where counter == STEPS−1: record carry-in to bit WIDTH−1 (ovf source) and final carry (cout); → DONE.
- DONE: out_valid=1; sum, cout, ovf and zero are stable until the handshake. On out_ready → IDLE. in_ready is not asserted in the same cycle.
- Subtraction identity: a−b−cin = a + ~b + !cin. cout is not inverted.
- zero is computed from the final sum register, combinationally or registered, and must be valid whenever out_valid=1.

## Timing
- Reset values: in_ready=1 during IDLE (after reset), out_valid=0, sum=0, cout=0, ovf=0, zero=1 (sum=0). Counter and carry are 0.
- Latency: input handshake at edge k → out_valid high after edge k+STEPS.
- Throughput: one operation per STEPS+2 cycles with out_ready held high.
- in_ready deasserts after the accept edge. It reasserts after the edge that completes the output handshake.
- Backpressure: with out_ready=0, DONE holds indefinitely and all outputs stay frozen.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; operands presented then are not captured.
- Reset mid-operation (RUN or DONE): next edge → IDLE, in-flight result discarded, all outputs take their reset values.
- Simultaneous rst and in_valid: reset wins, no capture.
- DIGIT=WIDTH: STEPS=1 and the block is fully parallel with 1-cycle compute.

## Test plan
- WIDTH=8, DIGIT=1, add 0x7F+0x01, cin=0 → sum=0x80, cout=0, ovf=1, zero=0; out_valid exactly 8 cycles after accept.
- WIDTH=8, DIGIT=1, add 0xFF+0x01, cin=1 → sum=0x01, cout=1, ovf=0; then 0xFF+0x01, cin=0 → sum=0x00, zero=1, cout=1.
- WIDTH=8, DIGIT=4, sub 0x00−0x01, cin=0 → sum=0xFF, cout=0, ovf=0, latency 2. Sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs constant, in_ready=0, in_valid pulses ignored. Release → one handshake, in_ready=1 next cycle.
- Reset asserted on RUN step 3 (WIDTH=8, DIGIT=1) → next cycle IDLE, out_valid=0, sum=0. A new op 0x10+0x20 then yields 0x30.
- Randomised 1000 ops for WIDTH∈{8,16}, DIGIT∈{1,2,4} with random stalls → sum, cout and ovf match the reference model.
